// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit feeder: default FIFO depth and launch FSM states.
package uart_pkg;

  localparam int unsigned DEPTH_LOG2_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } feeder_state_e;

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous byte FIFO with registered occupancy, full and empty flags.
// Pushes into a full FIFO and pops from an empty FIFO are ignored.
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [7:0]            wr_data,
  input  logic                  pop,
  output logic [7:0]            rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam int unsigned PTR_W = DEPTH_LOG2;
  localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push, do_pop;

  always_comb begin
    do_push  = push && !full_q;
    do_pop   = pop && !empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Flags come from the next count so they are registered alongside it.
    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign full    = full_q;
  assign empty   = empty_q;
  assign count   = count_q;

  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
    count_q <= CNT_W'(DEPTH));

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus launch FSM feeding uart_tx one byte per complete busy cycle.
// Optional UART_TX_FEEDER_OVF_EN adds a sticky overflow flag (ovf) for writes while full.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [7:0]          wr_data,
  output logic                full,
  output logic                empty,
  output logic [DEPTH_LOG2:0] count,
  output logic                tx_en,
  output logic [7:0]          tx_data,
  input  logic                tx_busy
`ifdef UART_TX_FEEDER_OVF_EN
  ,
  output logic                ovf
`endif
);

  feeder_state_e state_q, state_d;
  logic          tx_en_q, tx_en_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          pop;
  logic [7:0]    rd_data;

  uart_byte_fifo #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (wr_en),
    .wr_data (wr_data),
    .pop     (pop),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  always_comb begin
    state_d   = state_q;
    tx_en_d   = 1'b0;
    tx_data_d = tx_data_q;
    pop       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          tx_en_d   = 1'b1;
          tx_data_d = rd_data;
          state_d   = WAIT_BUSY;
        end
      end
      // Busy rises a cycle or more after the launch; wait for it before watching for its fall.
      WAIT_BUSY: begin
        if (tx_busy) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tx_en_q   <= 1'b0;
      tx_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      tx_en_q   <= tx_en_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign tx_en   = tx_en_q;
  assign tx_data = tx_data_q;

`ifdef UART_TX_FEEDER_OVF_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q | (wr_en & full);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif

  a_tx_en_single: assert property (@(posedge clk) disable iff (!rst_n)
    tx_en_q |=> !tx_en_q);

  a_tx_data_on_pop: assert property (@(posedge clk) disable iff (!rst_n)
    !$stable(tx_data_q) |-> tx_en_q);

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Randomized and directed bench for uart_tx_feeder against a transaction-level queue model.
module tb_uart_tx_feeder;

  localparam int unsigned DEPTH_LOG2 = 4;
  localparam int unsigned DEPTH      = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full, empty;
  logic [4:0] count;
  logic       tx_en;
  logic [7:0] tx_data;
  logic       tx_busy = 1'b0;
`ifdef UART_TX_FEEDER_OVF_EN
  logic       ovf;
`endif

  uart_tx_feeder #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .full    (full),
    .empty   (empty),
    .count   (count),
    .tx_en   (tx_en),
    .tx_data (tx_data),
    .tx_busy (tx_busy)
`ifdef UART_TX_FEEDER_OVF_EN
    ,
    .ovf     (ovf)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: accepted bytes in order, plus the launch handshake rule.
  logic [7:0] m_q[$];
  bit         m_wait;
  bit         m_seen_busy;
  bit         m_txen;
  logic [7:0] m_data;
  bit         m_ovf;

  // Responder standing in for uart_tx.
  int  u_lag = 2, u_dur = 4;
  int  u_lag_cnt = 0, u_busy_cnt = 0;
  bit  force_busy = 0;
  logic [7:0] launched[$];

  task automatic model_clear();
    m_q.delete();
    m_wait = 0; m_seen_busy = 0; m_txen = 0; m_data = 8'h00; m_ovf = 0;
    u_lag_cnt = 0; u_busy_cnt = 0; force_busy = 0;
  endtask

  task automatic model_edge();
    int size_before;
    size_before = m_q.size();
    m_txen = 0;
    if (m_wait) begin
      if (!m_seen_busy) begin
        if (tx_busy) m_seen_busy = 1;
      end else if (!tx_busy) begin
        m_wait = 0;
      end
    end else if (size_before > 0) begin
      m_data = m_q.pop_front();
      m_txen = 1;
      m_wait = 1;
      m_seen_busy = 0;
    end
    if (wr_en) begin
      if (size_before >= DEPTH) m_ovf = 1;
      else m_q.push_back(wr_data);
    end
  endtask

  task automatic compare_all();
    check("tx_en",   tx_en,   m_txen);
    check("tx_data", tx_data, m_data);
    check("count",   count,   m_q.size());
    check("empty",   empty,   m_q.size() == 0);
    check("full",    full,    m_q.size() == DEPTH);
`ifdef UART_TX_FEEDER_OVF_EN
    check("ovf",     ovf,     m_ovf);
`endif
  endtask

  task automatic step(input logic we, input logic [7:0] wd);
    @(negedge clk);
    wr_en   = we;
    wr_data = wd;
    if (u_lag_cnt > 0) begin
      u_lag_cnt--;
      if (u_lag_cnt == 0) u_busy_cnt = u_dur;
    end
    tx_busy = force_busy || (u_busy_cnt > 0);
    if (u_busy_cnt > 0) u_busy_cnt--;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    if (tx_en === 1'b1) begin
      u_lag_cnt = u_lag;
      launched.push_back(tx_data);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 3000; i++) begin
      if (m_q.size() == 0 && !m_wait) break;
      step(1'b0, 8'h00);
    end
    check("drain_empty", empty, 1'b1);
  endtask

  task automatic reset_check(input string tag);
    check({tag, "_tx_en"},   tx_en,   1'b0);
    check({tag, "_tx_data"}, tx_data, 8'h00);
    check({tag, "_count"},   count,   5'd0);
    check({tag, "_empty"},   empty,   1'b1);
    check({tag, "_full"},    full,    1'b0);
`ifdef UART_TX_FEEDER_OVF_EN
    check({tag, "_ovf"},     ovf,     1'b0);
`endif
  endtask

  initial begin
    model_clear();
    repeat (2) @(posedge clk);
    #1 reset_check("reset");
    @(negedge clk) rst_n = 1'b1;

    // Single byte: launch one cycle after the write edge.
    u_lag = 2; u_dur = 4;
    step(1'b1, 8'hA5);
    check("single_count_e0", count, 5'd1);
    step(1'b0, 8'h00);
    check("single_tx_en_e1", tx_en, 1'b1);
    check("single_data_e1",  tx_data, 8'hA5);
    check("single_empty_e1", empty, 1'b1);
    drain();

    // Burst of three with a long busy per byte.
    launched.delete();
    u_dur = 20;
    step(1'b1, 8'h11);
    step(1'b1, 8'h22);
    check("simul_wr_pop_count", count, 5'd1);
    step(1'b1, 8'h33);
    drain();
    repeat (25) step(1'b0, 8'h00);
    check("burst_pulses", launched.size(), 3);
    if (launched.size() == 3) begin
      check("burst_b0", launched[0], 8'h11);
      check("burst_b1", launched[1], 8'h22);
      check("burst_b2", launched[2], 8'h33);
    end

    // Fill to full behind an in-flight byte, then overflow.
    launched.delete();
    u_dur = 4;
    step(1'b1, 8'hEE);
    repeat (3) step(1'b0, 8'h00);
    force_busy = 1;
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i));
    step(1'b1, 8'hFF);
    check("fill_full",  full,  1'b1);
    check("fill_count", count, 5'd16);
`ifdef UART_TX_FEEDER_OVF_EN
    check("fill_ovf", ovf, 1'b1);
`endif
    step(1'b0, 8'h00);
    force_busy = 0;
    drain();
    repeat (8) step(1'b0, 8'h00);
    check("fill_launches", launched.size(), 17);
    if (launched.size() == 17) begin
      check("fill_first", launched[0], 8'hEE);
      for (int i = 0; i < 16; i++) check("fill_order", launched[i + 1], 8'(i));
    end

    // Busy rising late: FSM must hold without a second launch.
    u_lag = 4; u_dur = 3;
    step(1'b1, 8'h5A);
    step(1'b1, 8'hC3);
    drain();
    repeat (8) step(1'b0, 8'h00);

    // Reset while waiting on busy with five bytes queued.
    u_lag = 2; u_dur = 30;
    for (int i = 0; i < 6; i++) step(1'b1, 8'h40 + 8'(i));
    repeat (3) step(1'b0, 8'h00);
    check("pre_reset_count", count, 5'd5);
    @(negedge clk);
    wr_en = 1'b0; rst_n = 1'b0;
    model_clear();
    tx_busy = 1'b0;
    #1 reset_check("midrst");
    repeat (2) @(posedge clk);
    #1 reset_check("midrst_hold");
    @(negedge clk) rst_n = 1'b1;
    launched.delete();
    repeat (10) step(1'b0, 8'h00);
    check("post_reset_no_launch", launched.size(), 0);

    // Randomized traffic with varying uart timing.
    for (int i = 0; i < 800; i++) begin
      if (i % 40 == 0) begin
        u_lag = int'($urandom_range(1, 4));
        u_dur = int'($urandom_range(1, 25));
      end
      step(($urandom_range(0, 99) < 45), 8'($urandom));
    end
    drain();
    repeat (30) step(1'b0, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_feeder.md
Name: uart_tx_feeder

Overview:
Upstream stage of the UART transmitter: a byte FIFO plus a launch FSM that drains bytes one at a time into uart_tx.
- Producer writes bytes at any rate up to one per cycle.
- Feeder issues a single-cycle tx_en with stable tx_data, then waits for a full tx_busy high→low cycle before the next launch.
- Decouples bursty producers (command parsers, loopback, debug) from the serial bit rate.

Parameters:
DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 bytes (16)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
wr_en  input  1  producer write strobe; one byte per cycle
wr_data  input  8  byte to enqueue
full  output  1  FIFO holds 2**DEPTH_LOG2 bytes
empty  output  1  FIFO holds 0 bytes
count  output  DEPTH_LOG2+1  current occupancy
tx_en  output  1  one-cycle launch pulse to uart_tx
tx_data  output  8  byte to uart_tx; stable from tx_en until next launch
tx_busy  input  1  busy flag returned by uart_tx

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: tx_en=0, tx_data=8'h00, full=0, empty=1, count=0, FSM=IDLE, pointers=0, memory contents don't-care.
- FIFO:
  - Circular buffer; wr_ptr and rd_ptr are DEPTH_LOG2 bits and wrap modulo depth.
  - count is DEPTH_LOG2+1 bits; full=(count==DEPTH), empty=(count==0); all registered.
- Write: wr_en && !full → mem[wr_ptr]<=wr_data, wr_ptr++, count++.
- Write when full: byte silently dropped; no pointer or count change.
- Pop occurs only in IDLE when !empty: tx_data<=mem[rd_ptr], rd_ptr++, count--, tx_en<=1.
- Simultaneous write and pop: both happen; count unchanged.
- Write into an empty FIFO is not visible to the pop until the next cycle (no fall-through).
- FSM states:
  - IDLE: if !empty → pop, tx_en<=1, go WAIT_BUSY; else stay.
  - WAIT_BUSY: tx_en<=0; if tx_busy → WAIT_DONE; else stay. Covers the one-cycle lag between tx_en and busy rising.
  - WAIT_DONE: if !tx_busy → IDLE; else stay.
- Latency: wr_en sampled at edge E0 into an empty, idle block → tx_en high E1..E2 → earliest tx_busy seen at E3.
- Back-to-back: the next tx_en is no earlier than 1 cycle after tx_busy is sampled low.
- tx_en is never high for more than one cycle and never high while in WAIT_BUSY or WAIT_DONE.
- tx_data changes only on a pop.
- Reset mid-frame: everything returns to reset values immediately; queued bytes are lost.
  - uart_tx shares rst_n, so it aborts its frame too.

Optional Feature:
Macro UART_TX_FEEDER_OVF_EN.
- Defined: adds output port ovf (1 bit), reset 0.
  - Set sticky on any cycle with wr_en && full.
  - Cleared only by reset.
- Undefined: port and logic absent; drop-on-full behaviour is unchanged.

Decomposition:
- Shared package uart_pkg holds:
  - FSM state encoding localparams (IDLE=2'd0, WAIT_BUSY=2'd1, WAIT_DONE=2'd2).
  - Default DEPTH_LOG2.
- One sub-module is natural: uart_byte_fifo (sync FIFO carrying mem, pointers, count, full, empty; inputs push/pop).
- uart_tx_feeder instantiates uart_byte_fifo and holds the FSM and the tx_data/tx_en registers.

Test Plan:
- Single byte: write 8'hA5 with idle model → tx_en one cycle at E1, tx_data=8'hA5, count 1→0, empty re-asserts at E1.
- Burst of 3 bytes (8'h11, 8'h22, 8'h33) on consecutive cycles, with uart_tx model busy 20 cycles per byte:
  - Exactly three tx_en pulses, in order 11, 22, 33.
  - Each pulse at least 1 cycle after the previous busy falls.
- Fill 16 bytes (8'h00–8'h0F) while busy held high, then write 8'hFF:
  - full=1, count=16, 8'hFF dropped.
  - ovf=1 when UART_TX_FEEDER_OVF_EN is defined.
  - Drain yields 00..0F only.
- Simultaneous wr_en and pop with count=1: count stays 1, pointers both advance, and the next byte launches after the busy cycle.
- Busy late: tx_busy model rises 3 cycles after tx_en → FSM holds WAIT_BUSY with no second tx_en, then completes normally.
- Assert rst_n low in WAIT_DONE with count=5 → tx_en=0, count=0, empty=1, tx_data=8'h00; no tx_en after release until a new write.
